mmm_nlp_arb: RTL and testbench

MMM_NLP_ARB -- requirements
Module: mmm_nlp_arb

---
 rtl/mmm_nlp_arb.sv | 138 +++++++++++++
 tb/tb_mmm_nlp_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmm_nlp_arb.sv
// Two-port round-robin front end for one shared pipelined multiplier.
// Credits reserve FIFO space at accept time, so results are never dropped and each port returns in order.
module mmm_nlp_arb #(
    parameter int IDW = 90,
    parameter int ODW = 181,
    parameter int LAT = 3,
    parameter int FD  = 8
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_req0_valid,
    output logic           o_req0_ready,
    input  logic [IDW-1:0] i_req0_a,
    input  logic [IDW-1:0] i_req0_b,
    input  logic           i_req0_carry,
    input  logic           i_req1_valid,
    output logic           o_req1_ready,
    input  logic [IDW-1:0] i_req1_a,
    input  logic [IDW-1:0] i_req1_b,
    input  logic           i_req1_carry,
    output logic [IDW-1:0] o_mul_a,
    output logic [IDW-1:0] o_mul_b,
    output logic           o_mul_carry,
    input  logic [ODW-1:0] i_mul_res,
    output logic           o_rsp0_valid,
    input  logic           i_rsp0_ready,
    output logic [ODW-1:0] o_rsp0_data,
    output logic           o_rsp1_valid,
    input  logic           i_rsp1_ready,
    output logic [ODW-1:0] o_rsp1_data,
    output logic           o_busy
);
    localparam int AW = $clog2(FD);
    localparam int CW = AW + 1;

    logic [LAT-1:0]        tag_v;
    logic [LAT-1:0]        tag_id;
    logic                  rr_last;
    logic [1:0][AW-1:0]    wr_ptr;
    logic [1:0][AW-1:0]    rd_ptr;
    logic [1:0][CW-1:0]    cnt;
    logic [ODW-1:0]        mem [2][FD];

    logic [1:0][CW-1:0]    infl;
    logic [1:0][CW-1:0]    credit;
    logic [1:0]            req_valid;
    logic [1:0]            elig;
    logic [1:0]            gnt;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            rsp_ready;
    logic                  accept;

    assign req_valid = {i_req1_valid, i_req0_valid};
    assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

    always_comb begin
        infl = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            if (tag_v[i]) begin
                if (tag_id[i]) infl[1] = infl[1] + CW'(1);
                else           infl[0] = infl[0] + CW'(1);
            end
        end
    end

    // Ready is forced low while reset is asserted, even if a requester is already valid.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            credit[p] = CW'(FD) - cnt[p] - infl[p];
            elig[p]   = i_rstn & req_valid[p] & (credit[p] != '0);
            push[p]   = tag_v[LAT-1] & (tag_id[LAT-1] == 1'(p));
            pop[p]    = (cnt[p] != '0) & rsp_ready[p];
        end
        gnt[0] = elig[0] & (~elig[1] | rr_last);
        gnt[1] = elig[1] & (~elig[0] | ~rr_last);
        accept = gnt[0] | gnt[1];
    end

    assign o_req0_ready = gnt[0];
    assign o_req1_ready = gnt[1];

    always_comb begin
        o_mul_a     = '0;
        o_mul_b     = '0;
        o_mul_carry = 1'b0;
        if (gnt[0]) begin
            o_mul_a     = i_req0_a;
            o_mul_b     = i_req0_b;
            o_mul_carry = i_req0_carry;
        end else if (gnt[1]) begin
            o_mul_a     = i_req1_a;
            o_mul_b     = i_req1_b;
            o_mul_carry = i_req1_carry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tag_v   <= '0;
            tag_id  <= '0;
            rr_last <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
        end else begin
            tag_v[0]  <= accept;
            tag_id[0] <= gnt[1];
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (accept) rr_last <= gnt[1];
            for (int unsigned p = 0; p < 2; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
                case ({push[p], pop[p]})
                    2'b10:   cnt[p] <= cnt[p] + CW'(1);
                    2'b01:   cnt[p] <= cnt[p] - CW'(1);
                    default: cnt[p] <= cnt[p];
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned p = 0; p < 2; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= i_mul_res;
        end
    end

    assign o_rsp0_valid = (cnt[0] != '0);
    assign o_rsp1_valid = (cnt[1] != '0);
    assign o_rsp0_data  = o_rsp0_valid ? mem[0][rd_ptr[0]] : '0;
    assign o_rsp1_data  = o_rsp1_valid ? mem[1][rd_ptr[1]] : '0;
    assign o_busy       = (|tag_v) | o_rsp0_valid | o_rsp1_valid;

endmodule

// File: tb/tb_mmm_nlp_arb.sv
// Directed and randomised checks of the two-port multiplier arbiter against a per-port result scoreboard.
module tb_mmm_nlp_arb;
    localparam int IDW = 90;
    localparam int ODW = 181;
    localparam int LAT = 3;
    localparam int FD  = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [IDW-1:0] a0, b0, a1, b1;
    logic           cy0, cy1;
    logic [IDW-1:0] mul_a, mul_b;
    logic           mul_c;
    logic [ODW-1:0] mul_res;
    logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [ODW-1:0] rsp0_data, rsp1_data;
    logic           busy;

    int n_chk = 0;
    int n_err = 0;

    logic [ODW-1:0] q0[$];
    logic [ODW-1:0] q1[$];
    logic           acc0, acc1, rv0, rv1;
    logic [ODW-1:0] rd0, rd1, hold_d0, hold_d1;
    logic [IDW-1:0] ma;
    logic           hold0 = 1'b0, hold1 = 1'b0;
    logic [ODW-1:0] mp [LAT];

    mmm_nlp_arb #(.IDW(IDW), .ODW(ODW), .LAT(LAT), .FD(FD)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_a(a0), .i_req0_b(b0), .i_req0_carry(cy0),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_a(a1), .i_req1_b(b1), .i_req1_carry(cy1),
        .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_carry(mul_c),
        .i_mul_res(mul_res),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(rsp0_data),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(rsp1_data),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [ODW-1:0] mulf(logic [IDW-1:0] a, logic [IDW-1:0] b, logic c);
        logic [ODW-1:0] wa, wb;
        wa = ODW'(a);
        wb = ODW'(b);
        return wa * wb + ODW'(c);
    endfunction

    // Shared multiplier model with LAT cycles of latency.
    always @(posedge clk) begin
        mp[0] <= mulf(mul_a, mul_b, mul_c);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign mul_res = mp[LAT-1];

    task automatic chk(input string tag, input logic [ODW-1:0] got, input logic [ODW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs set; samples, scoreboards, advances one cycle.
    task automatic step();
        #1;
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        rv0  = rsp0_valid;
        rv1  = rsp1_valid;
        rd0  = rsp0_data;
        rd1  = rsp1_data;
        ma   = mul_a;
        if (hold0 && rv0) chk("rsp0_hold", rd0, hold_d0);
        if (hold1 && rv1) chk("rsp1_hold", rd1, hold_d1);
        hold0 = rv0 & ~rsp0_ready; hold_d0 = rd0;
        hold1 = rv1 & ~rsp1_ready; hold_d1 = rd1;
        if (rv0 && rsp0_ready) begin
            chk("q0_nonempty", ODW'(q0.size() != 0), 1);
            if (q0.size() != 0) chk("rsp0_data", rd0, q0.pop_front());
        end
        if (rv1 && rsp1_ready) begin
            chk("q1_nonempty", ODW'(q1.size() != 0), 1);
            if (q1.size() != 0) chk("rsp1_data", rd1, q1.pop_front());
        end
        if (acc0) q0.push_back(mulf(a0, b0, cy0));
        if (acc1) q1.push_back(mulf(a1, b1, cy1));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        q0.delete();
        q1.delete();
        hold0 = 1'b0;
        hold1 = 1'b0;
        #1 rstn = 1'b1;
    endtask

    initial begin
        int n0, n1, nrv;
        logic found;
        logic [ODW-1:0] big;

        rstn = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        a0 = 90'd7; b0 = 90'd9; cy0 = 1'b1;
        a1 = 90'd4; b1 = 90'd6; cy1 = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready0", ODW'(req0_ready), 0);
        chk("rst_ready1", ODW'(req1_ready), 0);
        chk("rst_rsp0_valid", ODW'(rsp0_valid), 0);
        chk("rst_rsp1_valid", ODW'(rsp1_valid), 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_mul_a", ODW'(mul_a), 0);
        chk("rst_busy", ODW'(busy), 0);
        idle();
        rstn = 1'b1;

        // single op: 3*5+1 on port 0, response at t+4
        req0_valid = 1'b1; a0 = 90'd3; b0 = 90'd5; cy0 = 1'b1;
        step();
        chk("t032_accept", ODW'(acc0), 1);
        chk("t032_mul_a", ODW'(ma), 3);
        idle();
        nrv = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("t032_valid_k%0d", k), ODW'(rv0), ODW'(k == 4));
            if (rv1) nrv++;
            if (k == 4) chk("t032_data", rd0, 16);
        end
        chk("t032_port1_silent", ODW'(nrv), 0);

        // all-ones operands
        req0_valid = 1'b1; a0 = '1; b0 = '1; cy0 = 1'b1;
        step();
        idle();
        big = (ODW'(1) << 180) - (ODW'(1) << 91) + ODW'(2);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            if (rv0) begin
                found = 1'b1;
                chk("t035_data", rd0, big);
            end
        end
        chk("t035_found", ODW'(found), 1);

        // round-robin alternation from reset
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        a0 = 90'd11; b0 = 90'd13; cy0 = 1'b0;
        a1 = 90'd17; b1 = 90'd19; cy1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t033_g0_%0d", i), ODW'(acc0), ODW'(i % 2 == 0));
            chk($sformatf("t033_g1_%0d", i), ODW'(acc1), ODW'(i % 2 == 1));
        end
        idle();
        for (int i = 0; i < 10; i++) step();

        // port 0 stalled: credit limit, one pop frees one slot, port 1 unaffected
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 30; i++) begin
            a0 = IDW'(i + 1); a1 = IDW'(i + 100);
            step();
            if (acc0) n0++;
            if (acc1) n1++;
        end
        chk("t034_accepts0", ODW'(n0), 8);
        chk("t034_ready0_low", ODW'(req0_ready), 0);
        chk("t034_port1_flow", ODW'(n1 >= 15), 1);
        rsp0_ready = 1'b1;
        step();
        chk("t034_pop_valid", ODW'(rv0), 1);
        rsp0_ready = 1'b0;
        n0 = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc0) n0++;
        end
        chk("t034_one_more", ODW'(n0), 1);
        idle();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("t034_q0_drained", ODW'(q0.size()), 0);
        chk("t034_q1_drained", ODW'(q1.size()), 0);

        // reset with work in flight and queued
        do_reset();
        req1_valid = 1'b1; rsp1_ready = 1'b0;
        step(); step();
        idle();
        for (int i = 0; i < 5; i++) step();
        req0_valid = 1'b1; rsp0_ready = 1'b1;
        step(); step(); step();
        chk("t036_pre_rv1", ODW'(rsp1_valid), 1);
        chk("t036_pre_busy", ODW'(busy), 1);
        rstn = 1'b0;
        #1;
        chk("t036_rst_ready0", ODW'(req0_ready), 0);
        chk("t036_rst_rv0", ODW'(rsp0_valid), 0);
        chk("t036_rst_rv1", ODW'(rsp1_valid), 0);
        chk("t036_rst_busy", ODW'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        q0.delete(); q1.delete();
        hold0 = 1'b0; hold1 = 1'b0;
        idle();
        rsp1_ready = 1'b1;
        rstn = 1'b1;
        nrv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rv0 || rv1) nrv++;
        end
        chk("t036_no_stale", ODW'(nrv), 0);
        chk("t036_busy", ODW'(busy), 0);
        req0_valid = 1'b1; rsp0_ready = 1'b0;
        n0 = 0;
        for (int i = 0; i < 20; i++) begin
            a0 = IDW'(i * 3 + 5);
            step();
            if (acc0) n0++;
        end
        chk("t036_credits", ODW'(n0), 8);
        idle();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            a0 = IDW'({$urandom(), $urandom(), $urandom()});
            b0 = IDW'({$urandom(), $urandom(), $urandom()});
            a1 = IDW'({$urandom(), $urandom(), $urandom()});
            b1 = IDW'({$urandom(), $urandom(), $urandom()});
            cy0 = 1'($urandom_range(0, 1));
            cy1 = 1'($urandom_range(0, 1));
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        idle();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("rand_q0_empty", ODW'(q0.size()), 0);
        chk("rand_q1_empty", ODW'(q1.size()), 0);
        chk("rand_busy", ODW'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
